bus_note_regs: RTL and testbench

Bus slave that sits directly upstream of the voice/oscillator datapath in TopLevel. It samples the asynchronous parallel synth bus (BusAddress, BusData, BusReadWrite, BusClock strobe) in the Clock domain and decodes writes into per-note control registers (Gate, Incr, WaveType, PulseWidth, Sustain, Linear). It also supports register readback and generates one-cycle gate-on/gate-off events for the envelope stage. TopLevel owns the BusData tristate; this block uses split in/out/enable data ports.

---
 rtl/bus_note_regs.sv | 196 +++++++++++++++++++
 tb/tb_bus_note_regs.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_note_regs.sv
// Bus slave for the synth note datapath: synchronizes the asynchronous parallel bus
// into Clock, decodes per-note control register writes/reads and emits gate events.
module bus_note_regs #(
    parameter int         NOTES     = 2,
    parameter logic [7:0] BASE_PAGE = 8'h00
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [15:0]          BusAddress,
    input  logic [7:0]           BusDataIn,
    input  logic                 BusReadWrite,
    input  logic                 BusClock,
    output logic [7:0]           BusDataOut,
    output logic                 BusDataOE,
    output logic [NOTES-1:0]     Gate,
    output logic [NOTES-1:0]     GateOn,
    output logic [NOTES-1:0]     GateOff,
    output logic [8*NOTES-1:0]   Incr,
    output logic [8*NOTES-1:0]   WaveType,
    output logic [8*NOTES-1:0]   PulseWidth,
    output logic [8*NOTES-1:0]   Sustain,
    output logic [NOTES-1:0]     Linear
);

    localparam logic [3:0] OFF_GATE   = 4'h0;
    localparam logic [3:0] OFF_INCR   = 4'h1;
    localparam logic [3:0] OFF_WAVE   = 4'h2;
    localparam logic [3:0] OFF_PW     = 4'h3;
    localparam logic [3:0] OFF_SUS    = 4'h4;
    localparam logic [3:0] OFF_LINEAR = 4'h5;

    // Strobe synchronizer and matching 2-stage delay of the bus payload
    logic        bclk_s1_q, bclk_s2_q, bclk_s3_q;
    logic [15:0] addr_d1_q, addr_d2_q;
    logic [7:0]  data_d1_q, data_d2_q;
    logic        rw_d1_q, rw_d2_q;
    logic        strobe;

    // Transaction stage: strobe and payload captured, committed one edge later
    logic        txn_valid_q;
    logic [15:0] txn_addr_q;
    logic [7:0]  txn_data_q;
    logic        txn_rw_q;

    // Register file and read port
    logic [NOTES-1:0]      gate_q, gate_d;
    logic [NOTES-1:0]      gate_on_q, gate_on_d;
    logic [NOTES-1:0]      gate_off_q, gate_off_d;
    logic [NOTES-1:0][7:0] incr_q, incr_d;
    logic [NOTES-1:0][7:0] wave_q, wave_d;
    logic [NOTES-1:0][7:0] pw_q, pw_d;
    logic [NOTES-1:0][7:0] sus_q, sus_d;
    logic [NOTES-1:0]      lin_q, lin_d;
    logic [7:0]            rdata_q, rdata_d;
    logic                  oe_q, oe_d;

    logic       page_hit, note_hit, hit;
    logic [3:0] note_field, note_idx, offset;

    assign strobe = bclk_s2_q & ~bclk_s3_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            // Reset high so a strobe held high through reset release is not seen as a rise.
            bclk_s1_q <= 1'b1;
            bclk_s2_q <= 1'b1;
            bclk_s3_q <= 1'b1;
            addr_d1_q <= '0;
            addr_d2_q <= '0;
            data_d1_q <= '0;
            data_d2_q <= '0;
            rw_d1_q   <= 1'b0;
            rw_d2_q   <= 1'b0;
        end else begin
            bclk_s1_q <= BusClock;
            bclk_s2_q <= bclk_s1_q;
            bclk_s3_q <= bclk_s2_q;
            addr_d1_q <= BusAddress;
            addr_d2_q <= addr_d1_q;
            data_d1_q <= BusDataIn;
            data_d2_q <= data_d1_q;
            rw_d1_q   <= BusReadWrite;
            rw_d2_q   <= rw_d1_q;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            txn_valid_q <= 1'b0;
            txn_addr_q  <= '0;
            txn_data_q  <= '0;
            txn_rw_q    <= 1'b0;
        end else begin
            txn_valid_q <= strobe;
            txn_addr_q  <= addr_d2_q;
            txn_data_q  <= data_d2_q;
            txn_rw_q    <= rw_d2_q;
        end
    end

    assign note_field = txn_addr_q[7:4];
    assign note_idx   = note_field - 4'd1;
    assign offset     = txn_addr_q[3:0];
    assign page_hit   = (txn_addr_q[15:8] == BASE_PAGE);
    assign note_hit   = (note_field != 4'd0) && (note_field <= 4'(NOTES));
    assign hit        = txn_valid_q && page_hit && note_hit;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        gate_d  = gate_q;
        incr_d  = incr_q;
        wave_d  = wave_q;
        pw_d    = pw_q;
        sus_d   = sus_q;
        lin_d   = lin_q;
        rdata_d = rdata_q;
        oe_d    = oe_q;

        if (!bclk_s2_q) begin
            oe_d = 1'b0;
        end

        if (hit) begin
            for (int n = 0; n < NOTES; n++) begin
                if (note_idx == 4'(n)) begin
                    if (txn_rw_q) begin
                        case (offset)
                            OFF_GATE:   gate_d[n] = txn_data_q[0];
                            OFF_INCR:   incr_d[n] = txn_data_q;
                            OFF_WAVE:   wave_d[n] = txn_data_q;
                            OFF_PW:     pw_d[n]   = txn_data_q;
                            OFF_SUS:    sus_d[n]  = txn_data_q;
                            OFF_LINEAR: lin_d[n]  = txn_data_q[0];
                            default:    ;
                        endcase
                    end else begin
                        oe_d = 1'b1;
                        case (offset)
                            OFF_GATE:   rdata_d = {7'd0, gate_q[n]};
                            OFF_INCR:   rdata_d = incr_q[n];
                            OFF_WAVE:   rdata_d = wave_q[n];
                            OFF_PW:     rdata_d = pw_q[n];
                            OFF_SUS:    rdata_d = sus_q[n];
                            OFF_LINEAR: rdata_d = {7'd0, lin_q[n]};
                            default:    rdata_d = 8'h00;
                        endcase
                    end
                end
            end
        end

        // Events are aligned with the Gate change and last one cycle since gate_q then settles.
        gate_on_d  = gate_d & ~gate_q;
        gate_off_d = ~gate_d & gate_q;
    end

    // NOTE: the register file is reset like any other state; the envelope stage relies on known zeros.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            gate_q     <= '0;
            gate_on_q  <= '0;
            gate_off_q <= '0;
            incr_q     <= '0;
            wave_q     <= '0;
            pw_q       <= '0;
            sus_q      <= '0;
            lin_q      <= '0;
            rdata_q    <= '0;
            oe_q       <= 1'b0;
        end else begin
            gate_q     <= gate_d;
            gate_on_q  <= gate_on_d;
            gate_off_q <= gate_off_d;
            incr_q     <= incr_d;
            wave_q     <= wave_d;
            pw_q       <= pw_d;
            sus_q      <= sus_d;
            lin_q      <= lin_d;
            rdata_q    <= rdata_d;
            oe_q       <= oe_d;
        end
    end

    assign Gate       = gate_q;
    assign GateOn     = gate_on_q;
    assign GateOff    = gate_off_q;
    assign Incr       = incr_q;
    assign WaveType   = wave_q;
    assign PulseWidth = pw_q;
    assign Sustain    = sus_q;
    assign Linear     = lin_q;
    assign BusDataOut = rdata_q;
    assign BusDataOE  = oe_q;

endmodule

// File: tb/tb_bus_note_regs.sv
// Directed bench for bus_note_regs: table of register writes plus hand-written
// sequences for latency, gate events, readback, misses and reset mid-transfer.
module tb_bus_note_regs;

    localparam int NOTES = 2;

    logic              Clock;
    logic              Reset;
    logic [15:0]       BusAddress;
    logic [7:0]        BusDataIn;
    logic              BusReadWrite;
    logic              BusClock;
    logic [7:0]        BusDataOut;
    logic              BusDataOE;
    logic [NOTES-1:0]  Gate, GateOn, GateOff, Linear;
    logic [8*NOTES-1:0] Incr, WaveType, PulseWidth, Sustain;

    bus_note_regs #(.NOTES(NOTES), .BASE_PAGE(8'h00)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .BusAddress  (BusAddress),
        .BusDataIn   (BusDataIn),
        .BusReadWrite(BusReadWrite),
        .BusClock    (BusClock),
        .BusDataOut  (BusDataOut),
        .BusDataOE   (BusDataOE),
        .Gate        (Gate),
        .GateOn      (GateOn),
        .GateOff     (GateOff),
        .Incr        (Incr),
        .WaveType    (WaveType),
        .PulseWidth  (PulseWidth),
        .Sustain     (Sustain),
        .Linear      (Linear)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    int on_cnt, off_cnt, both_cnt, oe_cnt;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // One bus transfer: strobe high for hi_cycles, then low; events observed for 8 cycles.
    task automatic run_xfer(input logic [15:0] addr, input logic [7:0] data, input logic rw,
                            input int hi_cycles);
        on_cnt = 0; off_cnt = 0; both_cnt = 0; oe_cnt = 0;
        @(negedge Clock);
        BusAddress   = addr;
        BusDataIn    = data;
        BusReadWrite = rw;
        BusClock     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (GateOn != '0)  on_cnt++;
            if (GateOff != '0) off_cnt++;
            if ((GateOn & GateOff) != '0) both_cnt++;
            if (BusDataOE) oe_cnt++;
            if (i == hi_cycles - 1) BusClock = 1'b0;
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] exp_incr;
        logic [15:0] exp_wave;
        logic [15:0] exp_pw;
        logic [15:0] exp_sus;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        vecs[0]  = '{16'h0011, 8'h0F, 16'h000F, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{16'h0012, 8'h01, 16'h000F, 16'h0001, 16'h0000, 16'h0000};
        vecs[2]  = '{16'h0013, 8'h3F, 16'h000F, 16'h0001, 16'h003F, 16'h0000};
        vecs[3]  = '{16'h0014, 8'h7F, 16'h000F, 16'h0001, 16'h003F, 16'h007F};
        vecs[4]  = '{16'h0021, 8'h03, 16'h030F, 16'h0001, 16'h003F, 16'h007F};
        vecs[5]  = '{16'h0022, 8'h10, 16'h030F, 16'h1001, 16'h003F, 16'h007F};
        vecs[6]  = '{16'h0023, 8'h00, 16'h030F, 16'h1001, 16'h003F, 16'h007F};
        vecs[7]  = '{16'h0024, 8'hAF, 16'h030F, 16'h1001, 16'h003F, 16'hAF7F};
        // Misses and ignored offsets leave everything unchanged
        vecs[8]  = '{16'h0031, 8'h55, 16'h030F, 16'h1001, 16'h003F, 16'hAF7F};
        vecs[9]  = '{16'h0111, 8'h55, 16'h030F, 16'h1001, 16'h003F, 16'hAF7F};
        vecs[10] = '{16'h0001, 8'h55, 16'h030F, 16'h1001, 16'h003F, 16'hAF7F};
        vecs[11] = '{16'h0016, 8'h55, 16'h030F, 16'h1001, 16'h003F, 16'hAF7F};
        vecs[12] = '{16'h00F4, 8'h55, 16'h030F, 16'h1001, 16'h003F, 16'hAF7F};

        Reset        = 1'b0;
        BusClock     = 1'b1;
        BusAddress   = 16'h0011;
        BusDataIn    = 8'hAA;
        BusReadWrite = 1'b1;

        // Reset released with BusClock held high: no transfer may happen
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        repeat (6) @(negedge Clock);
        check("hold_high incr", 32'(Incr), 32'h0);
        check("hold_high oe", 32'(BusDataOE), 32'h0);
        check("hold_high outs", {Gate, GateOn, GateOff, Linear, BusDataOut},
              32'h0);
        check("hold_high sustain", 32'(Sustain), 32'h0);

        // Write latency: update on the 3rd edge after the first sampled-high edge
        BusClock = 1'b0;
        repeat (2) @(negedge Clock);
        BusAddress   = 16'h0011;
        BusDataIn    = 8'h0F;
        BusReadWrite = 1'b1;
        BusClock     = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(posedge Clock);
            #1;
            if (k < 3) check($sformatf("latency edge%0d", k), 32'(Incr), 32'h0);
            else       check("latency edge3", 32'(Incr), 32'h000F);
            if (k == 1) BusClock = 1'b0;
        end
        repeat (3) @(negedge Clock);

        // Table of writes with cumulative expected register state
        for (int i = 0; i < NV; i++) begin
            run_xfer(vecs[i].addr, vecs[i].data, 1'b1, 1);
            check($sformatf("vec%0d incr", i), 32'(Incr), 32'(vecs[i].exp_incr));
            check($sformatf("vec%0d wave", i), 32'(WaveType), 32'(vecs[i].exp_wave));
            check($sformatf("vec%0d pw", i), 32'(PulseWidth), 32'(vecs[i].exp_pw));
            check($sformatf("vec%0d sus", i), 32'(Sustain), 32'(vecs[i].exp_sus));
            check($sformatf("vec%0d write_oe", i), 32'(oe_cnt), 32'd0);
        end
        check("table gate", 32'(Gate), 32'h0);

        // Gate events
        run_xfer(16'h0010, 8'h01, 1'b1, 1);
        check("gate_on gate", 32'(Gate), 32'h1);
        check("gate_on pulses", 32'(on_cnt), 32'd1);
        check("gate_on no_off", 32'(off_cnt), 32'd0);
        run_xfer(16'h0010, 8'h01, 1'b1, 1);
        check("gate_rewrite on", 32'(on_cnt), 32'd0);
        check("gate_rewrite off", 32'(off_cnt), 32'd0);
        run_xfer(16'h0020, 8'hFF, 1'b1, 1);
        check("gate1_on gate", 32'(Gate), 32'h3);
        check("gate1_on pulses", 32'(on_cnt), 32'd1);
        run_xfer(16'h0010, 8'h00, 1'b1, 1);
        check("gate_off gate", 32'(Gate), 32'h2);
        check("gate_off pulses", 32'(off_cnt), 32'd1);
        check("gate_off no_on", 32'(on_cnt), 32'd0);
        check("gate_off both", 32'(both_cnt), 32'd0);

        // Linear and readback
        run_xfer(16'h0015, 8'hFF, 1'b1, 1);
        check("linear", 32'(Linear), 32'h1);
        run_xfer(16'h0015, 8'h00, 1'b0, 1);
        check("read15 data", 32'(BusDataOut), 32'h01);
        check("read15 oe_cycles", 32'(oe_cnt), 32'd1);
        check("read15 oe_after", 32'(BusDataOE), 32'h0);
        run_xfer(16'h0024, 8'h00, 1'b0, 3);
        check("read24 data", 32'(BusDataOut), 32'hAF);
        check("read24 oe_cycles", 32'(oe_cnt), 32'd2);
        run_xfer(16'h0020, 8'h00, 1'b0, 1);
        check("read20 data", 32'(BusDataOut), 32'h01);
        run_xfer(16'h0016, 8'h00, 1'b0, 1);
        check("read16 data", 32'(BusDataOut), 32'h00);
        check("read16 oe_cycles", 32'(oe_cnt), 32'd1);
        run_xfer(16'h0013, 8'h00, 1'b0, 1);
        check("read13 data", 32'(BusDataOut), 32'h3F);

        // Read misses: no OE, data holds
        run_xfer(16'h0031, 8'h00, 1'b0, 1);
        check("rmiss note3 oe", 32'(oe_cnt), 32'd0);
        run_xfer(16'h0111, 8'h00, 1'b0, 1);
        check("rmiss page oe", 32'(oe_cnt), 32'd0);
        run_xfer(16'h0001, 8'h00, 1'b0, 1);
        check("rmiss note0 oe", 32'(oe_cnt), 32'd0);
        check("rmiss data_hold", 32'(BusDataOut), 32'h3F);

        // Reset asserted between the BusClock rise and the strobe
        @(negedge Clock);
        BusAddress   = 16'h0014;
        BusDataIn    = 8'h55;
        BusReadWrite = 1'b1;
        BusClock     = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        check("rst_mid sustain", 32'(Sustain), 32'h0);
        check("rst_mid incr", 32'(Incr), 32'h0);
        @(negedge Clock);
        BusClock = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        repeat (6) @(negedge Clock);
        check("rst_after sustain", 32'(Sustain), 32'h0);
        check("rst_after regs", {Incr, WaveType}, 32'h0);
        check("rst_after pw", 32'(PulseWidth), 32'h0);
        check("rst_after outs", {Gate, GateOn, GateOff, Linear, BusDataOut, 7'd0, BusDataOE},
              32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
